// File: rtl/alu_rs_entry.sv
// Single ALU reservation-station entry: holds one issued op, snoops the CDB
// for missing operands, executes locally, then broadcasts under MY_TAG.
package alu_rs_pkg;
  typedef enum logic [2:0] {
    NO_VAL = 3'd0, ALU_1 = 3'd1, ALU_2 = 3'd2, ALU_3 = 3'd3,
    ALU_4  = 3'd4, ALU_5 = 3'd5, ALU_6 = 3'd6, ALU_7 = 3'd7
  } rs_tag_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_OR = 3'd3,
    ALU_AND = 3'd4, ALU_SLT = 3'd5, ALU_SLTU = 3'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'd0, SH_SLL = 2'd1, SH_SRL = 2'd2, SH_SRA = 2'd3
  } shift_op_t;

  typedef struct packed {
    rs_tag_t     tag;
    logic [31:0] val;
  } cdb_t;
endpackage

module alu_rs_entry
  import alu_rs_pkg::*;
#(
  parameter rs_tag_t MY_TAG   = ALU_1,
  parameter int      EXEC_LAT = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  cdb_t        cdb_i,
  input  logic        write_en_i,
  input  logic [31:0] value1_i,
  input  logic [31:0] value2_i,
  input  rs_tag_t     tag1_i,
  input  rs_tag_t     tag2_i,
  input  alu_op_t     alu_op_i,
  input  shift_op_t   shift_op_i,
  output logic        busy_o,
  output logic        cdb_req_o,
  input  logic        cdb_gnt_i,
  output rs_tag_t     cdb_tag_o,
  output logic [31:0] cdb_val_o,
  output logic        proto_err_o
);

  localparam int DATA_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [2:0] LAT_M1 = 3'(EXEC_LAT - 1);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_val1;
  logic [DATA_W-1:0] r_val2;
  rs_tag_t           r_tag1;
  rs_tag_t           r_tag2;
  alu_op_t           r_alu_op;
  shift_op_t         r_sh_op;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_result;
  logic              r_proto_err;

  logic              w_snoop_hit;
  logic              w_fwd1;
  logic              w_fwd2;
  logic              w_rdy1;
  logic              w_rdy2;
  logic              w_cap1;
  logic              w_cap2;
  logic              w_ops_done;
  logic              w_req;
  logic [DATA_W-1:0] w_alu_res;

  function automatic logic [DATA_W-1:0] alu_calc(input alu_op_t op, input shift_op_t sh,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [4:0]               shamt;
    logic [DATA_W-1:0]        res;
    sa    = a;
    sb    = b;
    shamt = b[4:0];
    res   = '0;
    case (sh)
      SH_SLL:  res = a << shamt;
      SH_SRL:  res = a >> shamt;
      SH_SRA:  res = sa >>> shamt;
      default: begin
        case (op)
          ALU_ADD:  res = a + b;
          ALU_SUB:  res = a - b;
          ALU_XOR:  res = a ^ b;
          ALU_OR:   res = a | b;
          ALU_AND:  res = a & b;
          ALU_SLT:  res = {{(DATA_W-1){1'b0}}, (sa < sb)};
          ALU_SLTU: res = {{(DATA_W-1){1'b0}}, (a < b)};
          default:  res = '0;
        endcase
      end
    endcase
    return res;
  endfunction

  // A broadcast of our own tag (or no broadcast) never feeds an operand.
  assign w_snoop_hit = (cdb_i.tag != NO_VAL) && (cdb_i.tag != MY_TAG);
  assign w_fwd1      = w_snoop_hit && (tag1_i == cdb_i.tag);
  assign w_fwd2      = w_snoop_hit && (tag2_i == cdb_i.tag);
  assign w_rdy1      = w_fwd1 || (tag1_i == NO_VAL);
  assign w_rdy2      = w_fwd2 || (tag2_i == NO_VAL);
  assign w_cap1      = w_snoop_hit && (r_tag1 == cdb_i.tag);
  assign w_cap2      = w_snoop_hit && (r_tag2 == cdb_i.tag);
  assign w_ops_done  = ((r_tag1 == NO_VAL) || w_cap1) && ((r_tag2 == NO_VAL) || w_cap2);
  assign w_alu_res   = alu_calc(r_alu_op, r_sh_op, r_val1, r_val2);

  assign w_req       = (r_state == S_WB);
  assign busy_o      = (r_state != S_IDLE);
  assign cdb_req_o   = w_req;
  assign cdb_tag_o   = w_req ? MY_TAG : NO_VAL;
  assign cdb_val_o   = w_req ? r_result : '0;
  assign proto_err_o = r_proto_err;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state     <= S_IDLE;
      r_val1      <= '0;
      r_val2      <= '0;
      r_tag1      <= NO_VAL;
      r_tag2      <= NO_VAL;
      r_alu_op    <= ALU_ADD;
      r_sh_op     <= SH_NONE;
      r_cnt       <= '0;
      r_result    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (write_en_i && (r_state != S_IDLE)) r_proto_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (write_en_i) begin
            r_alu_op <= alu_op_i;
            r_sh_op  <= shift_op_i;
            r_val1   <= w_fwd1 ? cdb_i.val : value1_i;
            r_val2   <= w_fwd2 ? cdb_i.val : value2_i;
            r_tag1   <= w_fwd1 ? NO_VAL : tag1_i;
            r_tag2   <= w_fwd2 ? NO_VAL : tag2_i;
            r_cnt    <= LAT_M1;
            r_state  <= (w_rdy1 && w_rdy2) ? S_EXEC : S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_cap1) begin
            r_val1 <= cdb_i.val;
            r_tag1 <= NO_VAL;
          end
          if (w_cap2) begin
            r_val2 <= cdb_i.val;
            r_tag2 <= NO_VAL;
          end
          if (w_ops_done) begin
            r_cnt   <= LAT_M1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == 3'd0) begin
            r_result <= w_alu_res;
            r_state  <= S_WB;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_WB: begin
          if (cdb_gnt_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rs_entry.sv
// Directed bench for alu_rs_entry: two entries (EXEC_LAT 1 and 3) on a shared CDB,
// expected broadcasts queued at stimulus time and compared when cdb_req_o rises.
module tb_alu_rs_entry;
  import alu_rs_pkg::*;

  logic        clk;
  logic        rst_n;
  cdb_t        cdb;
  logic        we_a, we_b, gnt_a, gnt_b;
  logic [31:0] v1, v2;
  rs_tag_t     t1, t2;
  alu_op_t     aop;
  shift_op_t   sop;

  logic        busy_a, req_a, perr_a, busy_b, req_b, perr_b;
  rs_tag_t     tag_a, tag_b;
  logic [31:0] val_a, val_b;

  int   checks = 0;
  int   errors = 0;
  cdb_t sb[$];

  alu_rs_entry #(.MY_TAG(ALU_1), .EXEC_LAT(1)) u_a (
    .clk_i(clk), .reset_i(rst_n), .cdb_i(cdb), .write_en_i(we_a),
    .value1_i(v1), .value2_i(v2), .tag1_i(t1), .tag2_i(t2),
    .alu_op_i(aop), .shift_op_i(sop), .busy_o(busy_a), .cdb_req_o(req_a),
    .cdb_gnt_i(gnt_a), .cdb_tag_o(tag_a), .cdb_val_o(val_a), .proto_err_o(perr_a)
  );

  alu_rs_entry #(.MY_TAG(ALU_6), .EXEC_LAT(3)) u_b (
    .clk_i(clk), .reset_i(rst_n), .cdb_i(cdb), .write_en_i(we_b),
    .value1_i(v1), .value2_i(v2), .tag1_i(t1), .tag2_i(t2),
    .alu_op_i(aop), .shift_op_i(sop), .busy_o(busy_b), .cdb_req_o(req_b),
    .cdb_gnt_i(gnt_b), .cdb_tag_o(tag_b), .cdb_val_o(val_b), .proto_err_o(perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic req_of(input logic sel);
    return sel ? req_b : req_a;
  endfunction
  function automatic logic busy_of(input logic sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic rs_tag_t tag_of(input logic sel);
    return sel ? tag_b : tag_a;
  endfunction
  function automatic logic [31:0] val_of(input logic sel);
    return sel ? val_b : val_a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic issue(input logic sel, input alu_op_t op, input shift_op_t sh,
                       input logic [31:0] a, input logic [31:0] b,
                       input rs_tag_t tg1, input rs_tag_t tg2);
    aop = op; sop = sh; v1 = a; v2 = b; t1 = tg1; t2 = tg2;
    if (sel) we_b = 1'b1; else we_a = 1'b1;
    tick();
    we_a = 1'b0; we_b = 1'b0;
  endtask

  // Waits for the request, checks the latency from the last operand-ready edge,
  // then pops the scoreboard and compares the broadcast.
  task automatic wait_wb(input logic sel, input int lat, input string nm);
    int   n;
    cdb_t e;
    n = 0;
    while (!req_of(sel) && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_req"}, 32'(req_of(sel)), 32'd1);
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_sbsize"}, 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({nm, "_tag"}, 32'(tag_of(sel)), 32'(e.tag));
      chk({nm, "_val"}, val_of(sel), e.val);
    end
  endtask

  task automatic grant(input logic sel, input string nm);
    chk({nm, "_busy_gnt"}, 32'(busy_of(sel)), 32'd1);
    if (sel) gnt_b = 1'b1; else gnt_a = 1'b1;
    tick();
    gnt_a = 1'b0; gnt_b = 1'b0;
    chk({nm, "_busy_after"}, 32'(busy_of(sel)), 32'd0);
    chk({nm, "_req_after"}, 32'(req_of(sel)), 32'd0);
    chk({nm, "_tag_after"}, 32'(tag_of(sel)), 32'(NO_VAL));
  endtask

  task automatic run_case(input string nm, input alu_op_t op, input shift_op_t sh,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    sb.push_back(cdb_t'{ALU_1, exp});
    issue(1'b0, op, sh, a, b, NO_VAL, NO_VAL);
    wait_wb(1'b0, 1, nm);
    grant(1'b0, nm);
  endtask

  initial begin
    rst_n = 1'b0; cdb = cdb_t'{NO_VAL, 32'h0};
    we_a = 1'b0; we_b = 1'b0; gnt_a = 1'b0; gnt_b = 1'b0;
    v1 = '0; v2 = '0; t1 = NO_VAL; t2 = NO_VAL; aop = ALU_ADD; sop = SH_NONE;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_req_a",  32'(req_a),  32'd0);
    chk("rst_tag_a",  32'(tag_a),  32'(NO_VAL));
    chk("rst_val_a",  val_a,       32'd0);
    chk("rst_perr_a", 32'(perr_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    chk("rst_tag_b",  32'(tag_b),  32'(NO_VAL));

    // Ready-operand issue
    sb.push_back(cdb_t'{ALU_1, 32'd12});
    issue(1'b0, ALU_ADD, SH_NONE, 32'd5, 32'd7, NO_VAL, NO_VAL);
    chk("add_busy", 32'(busy_a), 32'd1);
    chk("add_req_early", 32'(req_a), 32'd0);
    wait_wb(1'b0, 1, "add");
    grant(1'b0, "add");

    // CDB snoop with an unrelated broadcast first
    issue(1'b0, ALU_SUB, SH_NONE, 32'hDEAD_0000, 32'd1, ALU_3, NO_VAL);
    tick();
    cdb = cdb_t'{ALU_4, 32'h55};
    tick();
    cdb = cdb_t'{NO_VAL, 32'h0};
    tick();
    chk("snoop_wait_busy", 32'(busy_a), 32'd1);
    chk("snoop_wait_req", 32'(req_a), 32'd0);
    cdb = cdb_t'{ALU_3, 32'h10};
    sb.push_back(cdb_t'{ALU_1, 32'hF});
    tick();
    cdb = cdb_t'{NO_VAL, 32'h0};
    wait_wb(1'b0, 1, "snoop");
    grant(1'b0, "snoop");

    // Same-cycle forwarding into both operands
    cdb = cdb_t'{ALU_2, 32'hCAFE_CAFE};
    sb.push_back(cdb_t'{ALU_1, 32'h0});
    issue(1'b0, ALU_XOR, SH_NONE, 32'h1111_1111, 32'h2222_2222, ALU_2, ALU_2);
    cdb = cdb_t'{NO_VAL, 32'h0};
    wait_wb(1'b0, 1, "fwd");
    grant(1'b0, "fwd");

    // Both waiting operands captured by one broadcast
    issue(1'b0, ALU_ADD, SH_NONE, 32'h9999, 32'h7777, ALU_2, ALU_2);
    tick(); tick();
    cdb = cdb_t'{ALU_2, 32'h1234};
    sb.push_back(cdb_t'{ALU_1, 32'h2468});
    tick();
    cdb = cdb_t'{NO_VAL, 32'h0};
    wait_wb(1'b0, 1, "dual");
    grant(1'b0, "dual");

    // Arithmetic, shift and compare corners
    run_case("add_wrap", ALU_ADD,  SH_NONE, 32'hFFFF_FFFF, 32'h1,          32'h0);
    run_case("sra",      ALU_ADD,  SH_SRA,  32'h8000_0000, 32'h21,         32'hC000_0000);
    run_case("slt_neg",  ALU_SLT,  SH_NONE, 32'hFFFF_FFFF, 32'h1,          32'h1);
    run_case("sltu_neg", ALU_SLTU, SH_NONE, 32'hFFFF_FFFF, 32'h1,          32'h0);
    run_case("slt_pos",  ALU_SLT,  SH_NONE, 32'h1,         32'hFFFF_FFFF,  32'h0);
    run_case("sltu_pos", ALU_SLTU, SH_NONE, 32'h1,         32'hFFFF_FFFF,  32'h1);
    run_case("sll",      ALU_OR,   SH_SLL,  32'h3,         32'h24,         32'h30);
    run_case("srl",      ALU_ADD,  SH_SRL,  32'h8000_0000, 32'h1F,         32'h1);
    run_case("sub_wrap", ALU_SUB,  SH_NONE, 32'h0,         32'h1,          32'hFFFF_FFFF);
    run_case("or",       ALU_OR,   SH_NONE, 32'hF0F0_F0F0, 32'h0F0F_0000,  32'hFFFF_F0F0);
    run_case("and",      ALU_AND,  SH_NONE, 32'hF0F0_F0F0, 32'h0FF0_0FF0,  32'h00F0_00F0);
    run_case("xor",      ALU_XOR,  SH_NONE, 32'hA5A5_A5A5, 32'hFFFF_FFFF,  32'h5A5A_5A5A);

    // EXEC_LAT=3 entry, grant stalled, illegal write during WB
    sb.push_back(cdb_t'{ALU_6, 32'h7B});
    issue(1'b1, ALU_ADD, SH_NONE, 32'd100, 32'd23, NO_VAL, NO_VAL);
    wait_wb(1'b1, 3, "lat3");
    for (int i = 0; i < 4; i++) begin
      chk("stall_req", 32'(req_b), 32'd1);
      chk("stall_tag", 32'(tag_b), 32'(ALU_6));
      chk("stall_val", val_b, 32'h7B);
      if (i == 1) begin
        aop = ALU_SUB; v1 = 32'h5; v2 = 32'h3; t1 = NO_VAL; t2 = NO_VAL;
        we_b = 1'b1;
      end
      tick();
      we_b = 1'b0;
    end
    chk("perr_b_set", 32'(perr_b), 32'd1);
    chk("perr_a_clear", 32'(perr_a), 32'd0);
    chk("wb_val_kept", val_b, 32'h7B);
    grant(1'b1, "lat3");
    chk("perr_b_sticky", 32'(perr_b), 32'd1);

    // Reset while waiting for an operand
    issue(1'b0, ALU_SUB, SH_NONE, 32'h0, 32'h1, ALU_3, NO_VAL);
    tick();
    chk("rw_busy_pre", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_busy", 32'(busy_a), 32'd0);
    chk("rw_req",  32'(req_a),  32'd0);
    chk("rw_tag",  32'(tag_a),  32'(NO_VAL));
    chk("rw_perr_b", 32'(perr_b), 32'd0);
    cdb = cdb_t'{ALU_3, 32'h5};
    tick();
    cdb = cdb_t'{NO_VAL, 32'h0};
    repeat (4) tick();
    chk("rw_late_busy", 32'(busy_a), 32'd0);
    chk("rw_late_req",  32'(req_a),  32'd0);

    // Reset while requesting the CDB
    sb.push_back(cdb_t'{ALU_1, 32'h3});
    issue(1'b0, ALU_ADD, SH_NONE, 32'h1, 32'h2, NO_VAL, NO_VAL);
    wait_wb(1'b0, 1, "rwb");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rwb_busy", 32'(busy_a), 32'd0);
    chk("rwb_req",  32'(req_a),  32'd0);
    chk("rwb_tag",  32'(tag_a),  32'(NO_VAL));
    chk("rwb_val",  val_a,       32'd0);
    cdb = cdb_t'{ALU_1, 32'h3};
    tick();
    cdb = cdb_t'{NO_VAL, 32'h0};
    tick();
    chk("rwb_late_busy", 32'(busy_a), 32'd0);
    chk("rwb_late_req",  32'(req_a),  32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rs_entry.md
Name: alu_rs_entry

Overview:
- One ALU reservation station entry of the Tomasulo back end. It sits directly downstream of issue logic: issue writes an op plus operand values/tags into it, and its busy bit feeds issue logic's busy_bus.
- Snoops the CDB for missing operands, executes the ALU/shift op locally once both operands are ready, then requests the CDB to broadcast its result under its own tag.
- NUM_RS instances form the RS bank.

Parameters:
MY_TAG, ALU_1, rs_tag_t identifier of this entry; broadcast on the CDB with the result; never NO_VAL.
EXEC_LAT, 1, execute cycles (1..7) between operands-ready and CDB request.

Ports:
clk_i  in  1  clock; all state updates on posedge
reset_i  in  1  synchronous reset, active-low (entry cleared when 0 at posedge)
cdb_i  in  cdb_t  CDB {tag, val}; tag NO_VAL = no broadcast this cycle
write_en_i  in  1  issue write strobe (this entry's bit of rs_write_en)
value1_i  in  32  operand 1 value; meaningful when tag1_i == NO_VAL
value2_i  in  32  operand 2 value (reg or imm/shamt); meaningful when tag2_i == NO_VAL
tag1_i  in  rs_tag_t  producer tag of operand 1; NO_VAL = value ready
tag2_i  in  rs_tag_t  producer tag of operand 2; NO_VAL = value ready
alu_op_i  in  alu_op_t  {ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLT, ALU_SLTU}
shift_op_i  in  shift_op_t  {SH_NONE, SH_SLL, SH_SRL, SH_SRA}; SH_NONE selects alu_op_i
busy_o  out  1  entry occupied (state != IDLE)
cdb_req_o  out  1  request to CDB arbiter; held until granted
cdb_gnt_i  in  1  arbiter grant; meaningful only while cdb_req_o = 1
cdb_tag_o  out  rs_tag_t  MY_TAG while cdb_req_o, else NO_VAL
cdb_val_o  out  32  result while cdb_req_o, else 0
proto_err_o  out  1  sticky: write_en_i asserted while busy_o = 1

Behaviour:
- Reset (reset_i = 0 at posedge):
  - state IDLE; busy_o, cdb_req_o, proto_err_o = 0; cdb_tag_o = NO_VAL; cdb_val_o = 0.
  - Stored values 0; stored tags NO_VAL; exec counter 0.
  - Reset mid-operation drops the entry; no broadcast occurs.
- States: IDLE, WAIT_OPS, EXEC, WB.
- IDLE, on posedge with write_en_i = 1:
  - Latch ops, values and tags.
  - Per operand: if tag != NO_VAL and tag == cdb_i.tag (cdb_i.tag != NO_VAL), latch cdb_i.val and mark ready (same-cycle forwarding). Otherwise ready iff tag == NO_VAL.
  - Next state: EXEC if both operands ready, else WAIT_OPS.
- WAIT_OPS:
  - Each posedge, any waiting operand whose tag == cdb_i.tag captures cdb_i.val; its tag becomes NO_VAL.
  - Both operands may capture in the same cycle.
  - Go to EXEC on the edge the last operand becomes ready.
  - cdb_i.tag == NO_VAL never matches.
- EXEC:
  - Counter loads EXEC_LAT-1 on entry and decrements each cycle; CDB is ignored.
  - At count 0: register the result and go to WB.
  - Net: operands-ready edge to first cdb_req_o cycle = EXEC_LAT cycles.
- Arithmetic, all 32-bit, wrap-around, no overflow flags:
  - ADD v1+v2; SUB v1-v2; XOR/OR/AND bitwise.
  - SLT: signed v1<v2 gives 1, else 0. SLTU: unsigned compare.
  - SLL v1<<v2[4:0]; SRL logical right; SRA arithmetic right.
  - Bits v2[31:5] are ignored for shifts.
- WB:
  - cdb_req_o = 1, cdb_tag_o = MY_TAG, cdb_val_o = result; all held stable until grant.
  - Posedge with cdb_gnt_i = 1: go to IDLE; busy_o = 0 from the next cycle.
  - The entry cannot be re-issued in the grant cycle (busy_o is still 1).
- Busy window: busy_o is 1 from the cycle after the issue edge through the grant cycle inclusive.
- write_en_i while state != IDLE: the write is ignored, entry contents are unchanged, and proto_err_o is set (cleared only by reset).
- cdb_gnt_i outside WB is ignored.
- Own result on cdb_i: no effect in any state.

Test Plan:
- Ready-operand issue: ADD, v1=5, v2=7, both tags NO_VAL, EXEC_LAT=1 -> busy_o=1 next cycle; cdb_req_o high 1 cycle after issue, cdb_val_o=12, cdb_tag_o=MY_TAG. gnt held high -> busy_o=0 the cycle after grant.
- CDB snoop: SUB, tag1=ALU_3, v2=1; 3 cycles later cdb_i={ALU_3, 32'h10} -> state EXEC on that edge; result 32'hF broadcast; an unrelated tag ALU_4 earlier is ignored.
- Same-cycle forwarding and dual capture:
  - Issue with tag1=tag2=ALU_2 while cdb_i={ALU_2, 32'hCAFE_CAFE}, XOR -> immediate EXEC, result 0.
  - Separately, both operands waiting on ALU_2 capture on one broadcast.
- Shift/compare corners:
  - SRA v1=32'h8000_0000, v2=32'h21 -> 32'hC000_0000 (shamt 1).
  - SLT v1=-1, v2=1 -> 1; SLTU same operands -> 0.
  - ADD 32'hFFFF_FFFF+1 -> 0.
- Arbitration stall and latency:
  - EXEC_LAT=3, gnt held low 4 cycles -> req/tag/val stable throughout.
  - write_en_i pulsed during WB -> contents unchanged, proto_err_o=1.
- Reset mid-operation: reset_i=0 during WAIT_OPS and during WB -> next cycle busy_o=0, cdb_req_o=0, cdb_tag_o=NO_VAL; a later CDB broadcast of the old tag causes no activity.
